// File: rtl/sort_pkg.sv
// sort_pkg: shared widths, requester-id sizing and controller state type for the sort block.
package sort_pkg;
    localparam int M = 4;
    localparam int N = 4;
    localparam int W = 6;
    localparam int NUM_REQ_DEF = 2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_REQ_DEF);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} ctrl_state_t;
endpackage

// File: rtl/sort_rr_arb.sv
// sort_rr_arb: one-hot round-robin grant, search starting at ptr.
module sort_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic [2*NUM_REQ-1:0] dbl, gdbl;
    logic [NUM_REQ-1:0]   rot, first;

    // rotate so ptr sits at bit 0, keep the lowest set bit, rotate back
    assign dbl   = {req, req} >> ptr;
    assign rot   = dbl[NUM_REQ-1:0];
    assign first = rot & (~rot + NUM_REQ'(1));
    assign gdbl  = {first, first} << ptr;
    assign gnt   = gdbl[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: shares one fixed-latency sort core between NUM_REQ requesters,
// one job at a time, with a held result until the consumer accepts it.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int SORT_LAT = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][N-1:0][M-1:0]    req_data,
    output logic [N-1:0][M-1:0]                 core_chi,
    input  logic [N-1:0][W-1:0]                 core_y,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [id_width(NUM_REQ)-1:0]        res_id,
    output logic [N-1:0][W-1:0]                 res_data,
    output logic                                busy
);
    localparam int IW = id_width(NUM_REQ);

    ctrl_state_t        state_q;
    logic [IW-1:0]      ptr_q;
    logic [3:0]         cnt_q;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win;

    sort_rr_arb #(.NUM_REQ(NUM_REQ), .PW(IW)) u_arb (
        .req(req_valid),
        .ptr(ptr_q),
        .gnt(gnt)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) win = IW'(i);
    end

    // gating with rst keeps a reset cycle from ever showing a grant
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            core_chi  <= '0;
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    core_chi <= req_data[win];
                    res_id   <= win;
                    cnt_q    <= 4'(SORT_LAT - 1);
                    ptr_q    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
                    state_q  <= WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    res_data  <= core_y;
                    res_valid <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: three controllers (SORT_LAT 2, 1, 7) on shared inputs, each with an
// inverting core stub, checked against a cycle-count reference model.
module tb_sort_ctrl;
    import sort_pkg::*;

    localparam int NR = 2;
    localparam int IW = id_width(NR);
    localparam int LAT [3] = '{2, 1, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic res_ready = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0][N-1:0][M-1:0] req_data = '0;

    logic [2:0][NR-1:0]         req_ready;
    logic [2:0][N-1:0][M-1:0]   core_chi;
    logic [2:0]                 res_valid, busy;
    logic [2:0][IW-1:0]         res_id;
    logic [2:0][N-1:0][W-1:0]   res_data;

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    logic [N-1:0][M-1:0] last_chi = '0;

    always #5 clk = ~clk;

    function automatic logic [N-1:0][W-1:0] inv(input logic [N-1:0][M-1:0] x);
        logic [N-1:0][W-1:0] r;
        logic [M-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = ~x[k];
            r[k] = W'(t);
        end
        return r;
    endfunction

    function automatic int winner(input logic [NR-1:0] m, input int p);
        for (int i = 0; i < NR; i++)
            if (m[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [N-1:0][W-1:0] sh [16];
        logic [N-1:0][W-1:0] y;
        sort_ctrl #(.NUM_REQ(NR), .SORT_LAT(LAT[g])) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready[g]), .req_data(req_data),
            .core_chi(core_chi[g]), .core_y(y),
            .res_valid(res_valid[g]), .res_ready(res_ready),
            .res_id(res_id[g]), .res_data(res_data[g]), .busy(busy[g])
        );
        // stub result is ready SORT_LAT cycles after the handshake edge that loads core_chi
        always @(posedge clk) begin
            sh[0] <= inv(core_chi[g]);
            for (int k = 1; k < 16; k++) sh[k] <= sh[k-1];
        end
        assign y = (LAT[g] == 1) ? inv(core_chi[g]) : sh[(LAT[g] > 1) ? LAT[g] - 2 : 0];
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) nxt();
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic run_job(input logic [NR-1:0] mask, input logic [NR-1:0][N-1:0][M-1:0] data);
        int w;
        int first [3];
        w = winner(mask, mptr);
        req_valid = mask;
        req_data = data;
        res_ready = 1'b1;
        first = '{-1, -1, -1};
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (req_ready[g] !== NR'(NR'(1) << w)) begin
                errors++;
                $display("FAIL job_grant g%0d: got %b want %b", g, req_ready[g], NR'(NR'(1) << w));
            end
        end
        nxt();
        req_valid = '0;
        mptr = (w + 1) % NR;
        last_chi = data[w];
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (res_valid[g] && first[g] < 0) begin
                    first[g] = c;
                    checks++;
                    if (res_id[g] !== IW'(w) || res_data[g] !== inv(data[w])) begin
                        errors++;
                        $display("FAIL job_result g%0d: got id %0d data %h want id %0d data %h",
                                 g, res_id[g], res_data[g], w, inv(data[w]));
                    end
                end
            end
            nxt();
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (first[g] != LAT[g] + 1) begin
                errors++;
                $display("FAIL job_latency g%0d: got %0d want %0d", g, first[g], LAT[g] + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({req_ready[g], busy[g], res_valid[g], res_id[g], res_data[g], core_chi[g]} !== '0) begin
                errors++;
                $display("FAIL reset_state g%0d: got rdy %b busy %b rv %b id %0d data %h chi %h want all 0",
                         g, req_ready[g], busy[g], res_valid[g], res_id[g], res_data[g], core_chi[g]);
            end
        end
        nxt();
        rst = 1'b0;
        req_valid = '0;
        mptr = 0;
    endtask

    task automatic test_single();
        logic [NR-1:0][N-1:0][M-1:0] d;
        do_reset();
        d[1] = {N*M{1'b0}} | $urandom;
        d[0] = {4'd6, 4'd0, 4'd5, 4'd7};
        run_job(2'b01, d);
    endtask

    task automatic test_latency();
        logic [NR-1:0][N-1:0][M-1:0] d;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < NR; r++) d[r] = (N*M)'($urandom);
            run_job(NR'($urandom_range(1, (1 << NR) - 1)), d);
        end
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < NR; r++) req_data[r] = (N*M)'($urandom);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (req_ready[g] !== '0 || busy[g] !== 1'b0 || core_chi[g] !== last_chi) begin
                    errors++;
                    $display("FAIL idle g%0d: got rdy %b busy %b chi %h want 0 0 %h",
                             g, req_ready[g], busy[g], core_chi[g], last_chi);
                end
            end
            nxt();
        end
    endtask

    task automatic test_rr(input bit rnd);
        int free_at, hs, w, exp_id, grants;
        logic [N-1:0][M-1:0] exp_d;
        logic [NR-1:0] exp_rdy;
        logic idle;
        do_reset();
        free_at = 0; hs = -100; grants = 0; exp_id = 0; exp_d = '0;
        for (int c = 0; c < 60; c++) begin
            req_valid = rnd ? NR'($urandom) : '1;
            for (int r = 0; r < NR; r++) req_data[r] = (N*M)'($urandom);
            @(negedge clk);
            idle = c >= free_at;
            w = idle ? winner(req_valid, mptr) : -1;
            exp_rdy = (w >= 0) ? NR'(NR'(1) << w) : '0;
            checks++;
            if (req_ready[0] !== exp_rdy || busy[0] !== !idle) begin
                errors++;
                $display("FAIL rr_grant c%0d: got rdy %b busy %b want %b %b", c, req_ready[0], busy[0], exp_rdy, !idle);
            end
            checks++;
            if (res_valid[0] !== (c == hs + LAT[0] + 1)) begin
                errors++;
                $display("FAIL rr_valid c%0d: got %b want %b", c, res_valid[0], c == hs + LAT[0] + 1);
            end else if (res_valid[0]) begin
                checks++;
                if (res_id[0] !== IW'(exp_id) || res_data[0] !== inv(exp_d)) begin
                    errors++;
                    $display("FAIL rr_result c%0d: got id %0d data %h want %0d %h", c, res_id[0], res_data[0], exp_id, inv(exp_d));
                end
            end
            if (w >= 0) begin
                hs = c;
                free_at = c + LAT[0] + 2;
                exp_d = req_data[w];
                exp_id = w;
                mptr = (w + 1) % NR;
                grants++;
            end
            nxt();
        end
        if (!rnd) begin
            checks++;
            if (grants != 60 / (LAT[0] + 2)) begin
                errors++;
                $display("FAIL rr_grant_count: got %0d want %0d", grants, 60 / (LAT[0] + 2));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0][M-1:0] d;
        do_reset();
        d = (N*M)'($urandom);
        req_valid = 2'b10;
        req_data[1] = d;
        res_ready = 1'b0;
        nxt();
        req_valid = '1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (res_valid[0]) break;
            nxt();
        end
        checks++;
        if (res_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: got res_valid %b want 1", res_valid[0]);
        end
        for (int k = 0; k < 5; k++) begin
            nxt();
            @(negedge clk);
            checks++;
            if (res_valid[0] !== 1'b1 || res_data[0] !== inv(d) || res_id[0] !== IW'(1) ||
                req_ready[0] !== '0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold k%0d: got rv %b data %h id %0d rdy %b busy %b want 1 %h 1 00 1",
                         k, res_valid[0], res_data[0], res_id[0], req_ready[0], busy[0], inv(d));
            end
        end
        nxt();
        res_ready = 1'b1;
        req_valid = '0;
        nxt();
        @(negedge clk);
        checks++;
        if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rv %b busy %b want 0 0", res_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        req_valid = 2'b01;
        req_data[0] = (N*M)'($urandom);
        nxt();
        req_valid = '0;
        nxt();
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (req_ready[g] !== '0) begin
                errors++;
                $display("FAIL rstmid_ready g%0d: got %b want 00", g, req_ready[g]);
            end
        end
        nxt();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({req_ready[g], busy[g], res_valid[g], res_id[g], res_data[g], core_chi[g]} !== '0) begin
                errors++;
                $display("FAIL rstmid_zero g%0d: got busy %b rv %b id %0d data %h chi %h want all 0",
                         g, busy[g], res_valid[g], res_id[g], res_data[g], core_chi[g]);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            nxt();
            @(negedge clk);
            seen = seen | (|res_valid);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_result: got res_valid seen %b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_idle();
        test_rr(1'b0);
        test_rr(1'b1);
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
